// File: rtl/ahb_lite_master.sv
// AHB-Lite initiator: converts a valid/ready request stream into pipelined single
// transfers and returns one response per accepted request.
module ahb_lite_master #(
    parameter int         AW        = 32,
    parameter int         DW        = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_size,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic          rsp_write,
    output logic          rsp_err,
    output logic          rsp_cancel,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic          HMASTLOCK,
    output logic [DW-1:0] HWDATA,
    input  logic [DW-1:0] HRDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    logic          ap_valid;
    logic [AW-1:0] ap_addr;
    logic [2:0]    ap_size;
    logic          ap_write;
    logic [DW-1:0] ap_wdata;
    logic          dp_valid;
    logic          dp_write;
    logic          cx_valid;
    logic          cx_write;
    logic          err_hold;
    logic          accept;
    logic          dp_done;
    logic          cancel_ap;
    logic          cx_report;
    logic [AW-1:0] aligned_addr;

    always_comb begin
        aligned_addr = req_addr;
        case (req_size)
            3'd1:    aligned_addr[0]   = 1'b0;
            3'd2:    aligned_addr[1:0] = 2'b00;
            default: ;
        endcase
    end

    // New requests are held off through the whole ERROR sequence so responses stay ordered.
    assign req_ready = HRESETn && !HRESP && !err_hold && !cx_valid && (!ap_valid || HREADY);
    assign accept    = req_valid && req_ready;
    assign dp_done   = HREADY && dp_valid;
    assign cancel_ap = !HREADY && HRESP && ap_valid;
    assign cx_report = cx_valid && !HRESP && !dp_done;

    assign HADDR     = ap_addr;
    assign HTRANS    = ap_valid ? 2'b10 : 2'b00;
    assign HWRITE    = ap_write;
    assign HSIZE     = ap_size;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ap_valid <= 1'b0;
            ap_addr  <= '0;
            ap_size  <= '0;
            ap_write <= 1'b0;
            ap_wdata <= '0;
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            HWDATA   <= '0;
            cx_valid <= 1'b0;
            cx_write <= 1'b0;
            err_hold <= 1'b0;
        end else begin
            err_hold <= HREADY && HRESP;
            if (HREADY) begin
                dp_valid <= ap_valid;
                dp_write <= ap_write;
                if (ap_valid) begin
                    HWDATA <= ap_wdata;
                end
            end
            // An idle AP may be loaded during a wait state; an occupied one only advances on HREADY.
            if (accept) begin
                ap_valid <= 1'b1;
                ap_addr  <= aligned_addr;
                ap_size  <= req_size;
                ap_write <= req_write;
                ap_wdata <= req_wdata;
            end else if (HREADY) begin
                ap_valid <= 1'b0;
            end else if (cancel_ap) begin
                ap_valid <= 1'b0;
                cx_valid <= 1'b1;
                cx_write <= ap_write;
            end
            if (cx_report) begin
                cx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_cancel <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_cancel <= 1'b0;
            rsp_rdata  <= '0;
            if (dp_done) begin
                rsp_valid <= 1'b1;
                rsp_write <= dp_write;
                rsp_err   <= HRESP;
                rsp_rdata <= (!dp_write && !HRESP) ? HRDATA : '0;
            end else if (cx_report) begin
                rsp_valid  <= 1'b1;
                rsp_write  <= cx_write;
                rsp_err    <= 1'b1;
                rsp_cancel <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: table of requests driven through a scoreboard,
// with a memory-backed AHB slave model that can insert wait states and ERROR responses.
module tb_ahb_lite_master;

    localparam logic [1:0] NONSEQ = 2'b10;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_write, rsp_err, rsp_cancel;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    ahb_lite_master #(.AW(32), .DW(32), .HPROT_VAL(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err),
        .rsp_cancel(rsp_cancel), .rsp_rdata(rsp_rdata),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int          waits;
        logic        err;
        logic [31:0] exp_haddr;
        logic        exp_err;
        logic        exp_cancel;
    } vec_t;

    typedef struct {
        logic        write;
        logic        err;
        logic        cancel;
        logic [31:0] rdata;
    } exp_t;

    vec_t        pend_q[$];
    vec_t        ap_q[$];
    exp_t        sb_q[$];
    vec_t        tbl[11];
    logic [31:0] mem[256];
    logic [31:0] shadow[256];

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_acc_cyc, last_ap_cyc, last_dp_cyc, last_rsp_cyc;
    bit   overlap_seen = 0;
    bit   sl_valid = 0;
    vec_t sl_rec;
    int   sl_waits;
    bit   sl_e1done;

    logic        p_hready = 1'b1, p_hresp = 1'b0, p_hwrite = 1'b0;
    logic [1:0]  p_htrans = 2'b00;
    logic [31:0] p_haddr = '0, p_hwdata = '0;
    logic [2:0]  p_hsize = '0;

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound or protocol violation at cycle %0d", name, cyc);
    endtask

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d,
                                          logic [31:0] a, logic [2:0] s);
        logic [3:0]  be;
        logic [31:0] r;
        r = old;
        case (s)
            3'd0:    be = 4'b0001 << a[1:0];
            3'd1:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    // One bus cycle: slave and requester drive at negedge, everything is sampled 1ns later.
    task automatic applyStimulus();
        vec_t v;
        exp_t e;
        @(negedge HCLK);
        cyc++;
        HRDATA = 32'h0BAD_F00D;
        HRESP  = 1'b0;
        HREADY = 1'b1;
        if (sl_valid && HRESETn) begin
            if (sl_rec.err) begin
                HRESP  = 1'b1;
                HREADY = sl_e1done;
            end else if (sl_waits > 0) begin
                HREADY = 1'b0;
            end else if (!sl_rec.write) begin
                HRDATA = mem[sl_rec.addr[9:2]];
            end
        end
        if (pend_q.size() > 0) begin
            req_valid = 1'b1;
            req_write = pend_q[0].write;
            req_addr  = pend_q[0].addr;
            req_size  = pend_q[0].size;
            req_wdata = pend_q[0].wdata;
        end else begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_size  = 3'($urandom_range(2));
            req_wdata = $urandom;
        end
        #1;
        if (rsp_valid) begin
            if (sb_q.size() == 0) begin
                failNow("rsp_unexpected");
            end else begin
                e = sb_q.pop_front();
                checkOutput("rsp_write", rsp_write, e.write);
                checkOutput("rsp_err", rsp_err, e.err);
                checkOutput("rsp_cancel", rsp_cancel, e.cancel);
                checkOutput("rsp_rdata", rsp_rdata, e.rdata);
                last_rsp_cyc = cyc;
            end
        end
        if (!p_hready && !p_hresp && p_htrans == NONSEQ) begin
            checkOutput("wait_haddr_stable", HADDR, p_haddr);
            checkOutput("wait_ctrl_stable", {HTRANS, HWRITE, HSIZE}, {p_htrans, p_hwrite, p_hsize});
            checkOutput("wait_hwdata_stable", HWDATA, p_hwdata);
        end
        if (!HREADY && HTRANS == NONSEQ) checkOutput("wait_req_ready", req_ready, 1'b0);
        if (sl_valid && HREADY) begin
            if (sl_rec.write && !sl_rec.err) begin
                checkOutput("hwdata", HWDATA, sl_rec.wdata);
                mem[sl_rec.addr[9:2]] = merge(mem[sl_rec.addr[9:2]], HWDATA, sl_rec.exp_haddr, sl_rec.size);
                if (HTRANS == NONSEQ && !HWRITE) overlap_seen = 1;
            end
            last_dp_cyc = cyc;
            sl_valid = 0;
        end else if (sl_valid && HRESP) begin
            sl_e1done = 1;
        end else if (sl_valid) begin
            sl_waits--;
        end
        if (HTRANS == NONSEQ && (HREADY || HRESP)) begin
            if (ap_q.size() == 0) begin
                failNow("htrans_unexpected");
            end else begin
                v = ap_q.pop_front();
                if (HREADY) begin
                    checkOutput("haddr", HADDR, v.exp_haddr);
                    checkOutput("hsize", HSIZE, v.size);
                    checkOutput("hwrite", HWRITE, v.write);
                    sl_valid  = 1;
                    sl_rec    = v;
                    sl_waits  = v.waits;
                    sl_e1done = 0;
                    last_ap_cyc = cyc;
                end
            end
        end
        if (req_valid && req_ready) begin
            v = pend_q.pop_front();
            ap_q.push_back(v);
            e.write  = v.write;
            e.err    = v.exp_err;
            e.cancel = v.exp_cancel;
            e.rdata  = '0;
            if (!v.write && !v.exp_err) e.rdata = shadow[v.addr[9:2]];
            if (v.write && !v.exp_err)
                shadow[v.addr[9:2]] = merge(shadow[v.addr[9:2]], v.wdata, v.exp_haddr, v.size);
            sb_q.push_back(e);
            last_acc_cyc = cyc;
        end
        p_hready = HREADY; p_hresp = HRESP; p_htrans = HTRANS; p_haddr = HADDR;
        p_hwrite = HWRITE; p_hsize = HSIZE; p_hwdata = HWDATA;
    endtask

    task automatic waitIdle(int maxCycles);
        int n = 0;
        while ((pend_q.size() > 0 || ap_q.size() > 0 || sb_q.size() > 0 || sl_valid) && n < maxCycles) begin
            applyStimulus();
            n++;
        end
        if (n >= maxCycles) failNow("timeout_idle");
        repeat (2) applyStimulus();
    endtask

    task automatic singleWriteLatency(logic [31:0] a, logic [31:0] d);
        pend_q.push_back('{1'b1, a, 3'd2, d, 0, 1'b0, a, 1'b0, 1'b0});
        waitIdle(40);
        checkOutput("lat_addr_phase", last_ap_cyc - last_acc_cyc, 1);
        checkOutput("lat_data_phase", last_dp_cyc - last_acc_cyc, 2);
        checkOutput("lat_rsp", last_rsp_cyc - last_acc_cyc, 3);
    endtask

    initial begin
        int  n;
        bit  seen;
        for (int i = 0; i < 256; i++) begin
            mem[i]    = '0;
            shadow[i] = '0;
        end
        HRESETn = 1'b0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        repeat (3) applyStimulus();
        checkOutput("reset_htrans", HTRANS, 2'b00);
        checkOutput("reset_req_ready", req_ready, 1'b0);
        checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset_haddr", HADDR, 32'h0);
        checkOutput("reset_hwdata", HWDATA, 32'h0);
        checkOutput("reset_hprot", HPROT, 4'b0011);
        checkOutput("const_hburst_hmastlock", {HBURST, HMASTLOCK}, 4'b0000);
        HRESETn = 1'b1;
        applyStimulus();

        singleWriteLatency(32'h100, 32'hDEADBEEF);

        //          write addr        size  wdata         waits err   exp_haddr    exp_err exp_cancel
        tbl[0]  = '{1'b1, 32'h200, 3'd2, 32'hCAFE0001, 0, 1'b0, 32'h200, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 32'h200, 3'd2, 32'h0,        0, 1'b0, 32'h200, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h100, 3'd2, 32'h0,        3, 1'b0, 32'h100, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 32'h104, 3'd2, 32'h12345678, 0, 1'b0, 32'h104, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 32'h103, 3'd1, 32'hBEEF0000, 0, 1'b0, 32'h102, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 32'h100, 3'd2, 32'h0,        0, 1'b0, 32'h100, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 32'h300, 3'd2, 32'h11111111, 0, 1'b1, 32'h300, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 32'h104, 3'd2, 32'h0,        0, 1'b0, 32'h104, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 32'h104, 3'd2, 32'h0,        0, 1'b0, 32'h104, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h10B, 3'd0, 32'h5A000000, 0, 1'b0, 32'h10B, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 32'h108, 3'd2, 32'h0,        1, 1'b0, 32'h108, 1'b0, 1'b0};
        for (int i = 0; i < 11; i++) pend_q.push_back(tbl[i]);
        waitIdle(300);
        checkOutput("read_overlaps_write_dphase", overlap_seen, 1'b1);
        checkOutput("mem_halfword_merge", mem[8'h40], 32'hBEEFBEEF);
        checkOutput("mem_error_write_dropped", mem[8'hC0], 32'h0);

        // Reset while a read is stalled and a second transfer waits in the address phase.
        pend_q.push_back('{1'b0, 32'h104, 3'd2, 32'h0, 6, 1'b0, 32'h104, 1'b0, 1'b0});
        pend_q.push_back('{1'b1, 32'h110, 3'd2, 32'h77777777, 0, 1'b0, 32'h110, 1'b0, 1'b0});
        n = 0;
        seen = 0;
        while (!seen && n < 30) begin
            applyStimulus();
            n++;
            seen = sl_valid && !HREADY && HTRANS == NONSEQ;
        end
        if (!seen) failNow("timeout_wait_state");
        HRESETn = 1'b0;
        #1;
        checkOutput("async_reset_htrans", HTRANS, 2'b00);
        checkOutput("async_reset_req_ready", req_ready, 1'b0);
        checkOutput("async_reset_rsp_valid", rsp_valid, 1'b0);
        pend_q.delete();
        ap_q.delete();
        sb_q.delete();
        sl_valid = 0;
        p_htrans = 2'b00;
        repeat (3) applyStimulus();
        HRESETn = 1'b1;
        applyStimulus();
        singleWriteLatency(32'h140, 32'h600DCAFE);
        pend_q.push_back('{1'b0, 32'h140, 3'd2, 32'h0, 0, 1'b0, 32'h140, 1'b0, 1'b0});
        waitIdle(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Synthesizable AHB-Lite initiator. Converts a simple valid/ready request stream into pipelined AHB-Lite single transfers.
- Returns one response per accepted request.
- Drives the slave-side bus of ahb_lite_sdram (and any AHB-Lite responder) from on-chip logic, e.g. a DMA engine or a hardware traffic generator. This replaces the software driver in bring-up benches.
- At most two transfers are in flight: one in the address phase and one in the data phase.

Parameters:
- AW, 32, HADDR and req_addr width.
- DW, 32, HWDATA/HRDATA width; only 32 is supported.
- HPROT_VAL, 4'b0011, constant HPROT value (non-cacheable, privileged, data).

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on a rising HCLK edge when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  AW  byte address.
- req_size  in  3  HSIZE encoding; 0..2 only.
- req_wdata  in  DW  write data, already placed on the correct byte lanes (little-endian).
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_write  out  1  direction of the responded transfer.
- rsp_err  out  1  transfer ended with ERROR or was cancelled.
- rsp_cancel  out  1  transfer was never completed on the bus (flushed by a preceding ERROR).
- rsp_rdata  out  DW  HRDATA captured for a read; 0 for writes and errors.
- HADDR  out  AW  address.
- HTRANS  out  2  IDLE (2'b00) or NONSEQ (2'b10) only.
- HWRITE  out  1  write.
- HSIZE  out  3  size.
- HBURST  out  3  constant 3'b000 (SINGLE).
- HPROT  out  4  HPROT_VAL.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  DW  write data for the current data phase.
- HRDATA  in  DW  read data.
- HREADY  in  1  bus ready from the slave mux.
- HRESP  in  1  0 = OKAY, 1 = ERROR.

Behaviour:
- Reset: all outputs go low immediately and asynchronously, except HPROT = HPROT_VAL. This gives HTRANS = IDLE, rsp_valid = 0, req_ready = 0. Both pipeline stages are emptied. A reset mid-transfer emits no response for in-flight transfers.
- Stages:
  - AP (address phase): valid, addr, size, write, wdata.
  - DP (data phase): valid, write, wdata.
  - HADDR, HTRANS, HWRITE and HSIZE are registered from AP. HTRANS = NONSEQ iff AP valid.
  - HWDATA is registered from DP wdata and held while DP is valid; otherwise it holds its last value.
- Alignment: HADDR = req_addr with the low bits cleared per req_size (size 1 clears bit 0; size 2 clears bits 1:0). Behaviour for req_size > 2 is undefined.
- Advance: at each HCLK edge with HREADY = 1 and no error pending:
  - DP completes, and a response is registered for the next cycle.
  - AP moves to DP.
  - An accepted request loads AP.
- req_ready = HRESETn released && (!AP_valid || (HREADY && !HRESP)). This is a combinational path from HREADY by design.
- Wait states: while HREADY = 0, all H* outputs, AP and DP hold stable.
- Latency with zero wait states: request accepted at edge N.
  - Address phase is cycle N+1.
  - Data phase is cycle N+2.
  - rsp_valid is high in cycle N+3.
  - Back-to-back requests sustain one transfer per cycle.
- Response: registered; rsp_valid for exactly 1 cycle. rsp_rdata = HRDATA sampled at the completing edge for reads.
- ERROR handling (two-cycle response):
  - Cycle E1 (HREADY = 0, HRESP = 1): at the end of E1, if AP is valid, HTRANS is forced to IDLE for E2. AP contents move to a one-entry "cancelled" slot.
  - Cycle E2 (HREADY = 1, HRESP = 1): DP completes with rsp_err = 1 in cycle E2+1.
  - If a cancelled entry exists, it is reported in cycle E2+2 with rsp_err = 1 and rsp_cancel = 1.
  - req_ready is 0 during E1, E2 and E2+1, so response order is preserved.
- Ordering: responses come out strictly in request order. Never two rsp_valid pulses in the same cycle.
- HRESP = 1 with HREADY = 1 and no preceding E1 is treated as an ERROR completion of DP: rsp_err = 1, and no cancellation.

Test Plan:
1. Zero-wait single write, req_addr = 0x100, wdata = 0xDEADBEEF, size 2, accepted at edge N → NONSEQ with HADDR = 0x100 in N+1; HWDATA = 0xDEADBEEF in N+2; rsp_valid in N+3 with rsp_err = 0.
2. With ahb_lite_sdram + sdr model: write 0xCAFE0001 to 0x200, then back-to-back read of 0x200 → the read NONSEQ overlaps the write data phase; read rsp_rdata = 0xCAFE0001.
3. Slave inserts 3 wait states on a read with a second request pending → H* stable for 3 cycles, req_ready = 0, responses in order, each exactly 1 cycle.
4. ERROR on transfer A with B in the address phase → HTRANS = IDLE in E2; rsp A err = 1 in E2+1; rsp B err = 1, cancel = 1 in E2+2; B never reaches the data phase.
5. Halfword write to req_addr = 0x103, size 1 → HADDR = 0x102, HSIZE = 3'b001.
6. Assert HRESETn = 0 during a wait state → HTRANS = 0 immediately (before the next edge); no rsp_valid; first request after release behaves as in scenario 1.
